// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the serial comparator: FSM state encoding and
// the one-hot {gt,eq,lt} result encoding.
package serial_cmp_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_SCAN = S_SCAN,
    ST_DONE = S_DONE
  } state_t;

  // Result vector ordering is {gt, eq, lt}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

endpackage

// File: rtl/serial_cmp_ctrl_cell.sv
// Purely combinational one-bit magnitude compare cell, time-shared by the
// serial comparator across all bit positions.
module cmp_bit_cell (
  input  logic x,
  input  logic y,
  output logic gt_o,
  output logic eq_o,
  output logic lt_o
);

  assign gt_o = x & ~y;
  assign eq_o = ~(x ^ y);
  assign lt_o = ~x & y;

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Serial MSB-first comparator controller. Operands are latched on an
// accepted start and scanned one bit per clock through a single compare
// cell; the scan stops at the first differing bit.
// Optional build macro: SERIAL_CMP_SIGNED_EN -- treat operands as two's
// complement by inverting the decision at the sign bit only.
module serial_cmp_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IDX_W-1:0] idx;

  logic bit_a;
  logic bit_b;
  logic c_gt;
  logic c_eq;
  logic c_lt;
  logic flip;
  logic [2:0] res_nxt;

  // Map a cell decision onto the {gt,eq,lt} vector; flip swaps gt/lt
  // for the sign bit of a two's complement compare.
  function automatic logic [2:0] bit_decision(input logic gt_c, input logic eq_c,
                                              input logic lt_c, input logic flip_c);
    logic a_wins;
    a_wins = (gt_c & ~flip_c) | (lt_c & flip_c);
    if (eq_c)
      return RES_EQ;
    else if (a_wins)
      return RES_GT;
    else
      return RES_LT;
  endfunction

  assign bit_a = a_r[idx];
  assign bit_b = b_r[idx];

`ifdef SERIAL_CMP_SIGNED_EN
  assign flip = (idx == IDX_TOP);
`else
  assign flip = 1'b0;
`endif

  cmp_bit_cell u_cell (
    .x    (bit_a),
    .y    (bit_b),
    .gt_o (c_gt),
    .eq_o (c_eq),
    .lt_o (c_lt)
  );

  assign res_nxt = bit_decision(c_gt, c_eq, c_lt, flip);

  // Control FSM with operand capture, bit index and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      {gt, eq, lt} <= RES_NONE;
      a_r          <= '0;
      b_r          <= '0;
      idx          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_r          <= a;
            b_r          <= b;
            idx          <= IDX_TOP;
            {gt, eq, lt} <= RES_NONE;
            busy         <= 1'b1;
            state        <= ST_SCAN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          // Leave on the first difference, or unconditionally at bit 0
          if (!c_eq || (idx == '0)) begin
            {gt, eq, lt} <= res_nxt;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= ST_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Self-checking bench for serial_cmp_ctrl (WIDTH=8). A reference model
// pushes expected result and latency into a scoreboard when a start is
// issued; a monitor pops and compares on every done pulse.
module tb_serial_cmp_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [2:0] res;
    int         lat;
    int         s;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t hold_e;

  serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .gt    (gt),
    .eq    (eq),
    .lt    (lt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: first differing bit from the MSB gives latency, ordinary
  // (signed or unsigned) comparison gives the result.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input int s);
    exp_t e;
    bit found;
    found = 1'b0;
    e.s   = s;
    e.lat = WIDTH;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && (x[i] != y[i])) begin
        found = 1'b1;
        e.lat = WIDTH - i;
      end
    end
`ifdef SERIAL_CMP_SIGNED_EN
    if ($signed(x) > $signed(y))      e.res = 3'b100;
    else if ($signed(x) < $signed(y)) e.res = 3'b001;
    else                              e.res = 3'b010;
`else
    if (x > y)      e.res = 3'b100;
    else if (x < y) e.res = 3'b001;
    else            e.res = 3'b010;
`endif
    return e;
  endfunction

  // Monitor: score every done pulse, and require cleared results while busy
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", {29'd0, gt, eq, lt}, {29'd0, mon_e.res});
        check("latency", cyc - mon_e.s - 1, mon_e.lat);
        check("done_not_busy", {31'd0, busy}, 32'd0);
      end
    end
    if (rst_n && busy)
      check("busy_res_clear", {29'd0, gt, eq, lt}, 32'd0);
  end

  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input bit push = 1'b1);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    if (push) sb_q.push_back(model(x, y, cyc));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    bit seen;
    i    = 0;
    seen = 1'b0;
    while (!seen && i < budget) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      i++;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", {27'd0, busy, done, gt, eq, lt}, 32'd0);

    // Idle with start low
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_outs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    end

    // Differ at MSB, then verify the result holds
    issue(8'hA5, 8'h3C);
    hold_e = model(8'hA5, 8'h3C, 0);
    wait_done(12);
    repeat (3) @(negedge clk);
    check("hold_res", {29'd0, gt, eq, lt}, {29'd0, hold_e.res});
    check("hold_idle", {30'd0, busy, done}, 32'd0);

    // Differ at LSB, then equal operands, then sign-bit case
    issue(8'h5A, 8'h5B);
    wait_done(12);
    issue(8'h77, 8'h77);
    wait_done(12);
    issue(8'h80, 8'h01);
    wait_done(12);

    // Start during scan is ignored; start in DONE is accepted back-to-back
    issue(8'h10, 8'h11);
    repeat (2) @(negedge clk);
    issue(8'hFF, 8'h00, 1'b0);
    wait_done(12);
    a     = 8'hC3;
    b     = 8'hC4;
    start = 1'b1;
    sb_q.push_back(model(8'hC3, 8'hC4, cyc));
    @(posedge clk);
    #1;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done(12);

    // Reset during the fourth scan cycle
    issue(8'h01, 8'h02);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    check("rst_hold_outs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'h01, 8'h02);
    wait_done(12);

    // Random operands, every third pair forced equal
    for (int i = 0; i < 8; i++) begin
      ra = WIDTH'($urandom);
      rb = (i % 3 == 0) ? ra : WIDTH'($urandom);
      issue(ra, rb);
      wait_done(12);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_cmp_ctrl.md
Name: serial_cmp_ctrl

Overview:
- Sequencer that compares two WIDTH-bit operands MSB-first, one bit per clock, through a single one-bit compare cell.
- Stops at the first differing bit and reports greater, equal or less.
- Sits between a requester that issues start/operands and the shared one-bit comparator datapath; trades area for latency.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2.
- IDX_W, $clog2(WIDTH), width of the internal bit-index counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy==0
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- busy  output  1  high while scanning
- done  output  1  one-cycle pulse; result valid
- gt  output  1  A > B
- eq  output  1  A == B
- lt  output  1  A < B

Behaviour:
- Reset (rst_n low, async): state IDLE; busy, done, gt, eq and lt all 0; operand registers and index cleared.
- States: IDLE, SCAN, DONE.
- IDLE or DONE with start==1:
  - capture a and b; idx <= WIDTH-1.
  - clear gt, eq and lt; go to SCAN; busy=1 from the next cycle.
- SCAN, each cycle: the compare cell sees bit a_r[idx] and b_r[idx].
  - Bits differ: set gt or lt from the cell, go to DONE.
  - Bits equal and idx==0: set eq, go to DONE.
  - Bits equal and idx>0: idx <= idx-1, stay in SCAN.
- DONE: done=1 for exactly this cycle; busy=0. Go to IDLE, or to SCAN if start==1 (back-to-back accepted).
- Latency: done is high in the cycle beginning k edges after the start-sampling edge.
  - k = WIDTH - p, where p is the index of the first differing bit.
  - k = WIDTH when operands are equal.
  - Minimum 1, maximum WIDTH.
- Result hold: gt, eq and lt stay valid after done until the next accepted start. Exactly one of them is 1 after any completed compare; all are 0 while busy or after reset.
- start while busy==1: ignored; operands are not re-captured and there is no error indication.
- Operand inputs change during SCAN: no effect (registered copies are used).
- Reset asserted mid-scan: immediate return to IDLE. No done pulse; results cleared.
- idx never wraps below 0; the SCAN exit at idx==0 is unconditional.

Optional Feature:
- Macro: SERIAL_CMP_SIGNED_EN
- Defined: operands are two's complement. At idx==WIDTH-1 only, differing bits give the inverted decision: A bit=1 means lt, A bit=0 means gt. Lower bits are unchanged.
- Undefined: unsigned magnitude compare at all bit positions.
- Latency is identical in both builds.

Decomposition:
- Shared package serial_cmp_pkg:
  - state encoding constants S_IDLE=2'd0, S_SCAN=2'd1, S_DONE=2'd2;
  - result encoding constants for the {gt,eq,lt} vector.
- Sub-module cmp_bit_cell: purely combinational one-bit comparator.
  - Inputs: x, y.
  - Outputs: gt_o = x&~y, eq_o = ~(x^y), lt_o = ~x&y.
  - Instantiated once; the controller supplies the indexed bits.
- The controller holds the FSM, operand registers, index counter and result registers.

Test Plan (WIDTH=8):
- Reset then idle, start=0 for 5 cycles -> busy=done=gt=eq=lt=0 throughout.
- a=8'hA5, b=8'h3C, start 1 cycle -> differ at bit 7, done 1 edge after start, gt=1 eq=0 lt=0; result holds until next start.
- a=8'h5A, b=8'h5B -> differ at bit 0, done 8 edges after start, lt=1. Then a=8'h77, b=8'h77 -> done 8 edges after start, eq=1.
- a=8'h80, b=8'h01 -> gt=1 without SERIAL_CMP_SIGNED_EN; lt=1 with it, done 1 edge after start in both builds.
- Start a=8'h10, b=8'h11; pulse start with a=8'hFF, b=8'h00 mid-scan -> second start ignored, done at edge 8, lt=1. Start asserted in the DONE cycle -> accepted back-to-back, busy=1 next cycle.
- Start a=8'h01, b=8'h02; drop rst_n during the 4th SCAN cycle -> outputs 0 immediately, no done pulse; after release, a fresh compare completes normally.
